// File: rtl/size_deconvert_if.sv
// Word-in / byte-out bus bundle for size_deconvert.
// Signal names match the PHY datapath netlist; slave is the DUT side, master drives words in.
interface size_deconvert_if #(
    parameter int SIZE = 32
);
    logic [SIZE-1:0] DATA_IN;
    logic            VALID_IN;
    logic            READY_OUT;
    logic [7:0]      DATA_OUT;
    logic            VALID_OUT;
    logic            IDLE_BUFFER;

    modport slave (
        input  DATA_IN, VALID_IN,
        output READY_OUT, DATA_OUT, VALID_OUT, IDLE_BUFFER
    );

    modport master (
        output DATA_IN, VALID_IN,
        input  READY_OUT, DATA_OUT, VALID_OUT, IDLE_BUFFER
    );
endinterface

// File: rtl/size_deconvert.sv
// Serialises SIZE-bit words into bytes (one per PCLK), with a one-word skid and idle insertion.
// Define SIZE_DECONVERT_MSB_FIRST_EN to emit the most-significant byte first.
module size_deconvert #(
    parameter int         SIZE        = 32,
    parameter logic [7:0] IDLE_SYMBOL = 8'h7C
) (
    input  logic            PCLK,
    input  logic            RESET,
    size_deconvert_if.slave bus
);
    localparam int N     = SIZE / 8;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int LANES = 2 ** CNT_W;

    generate
        if (SIZE != 8 && SIZE != 16 && SIZE != 32) begin : gSizeCheck
            $error("size_deconvert: SIZE must be 8, 16 or 32");
        end
    endgenerate

    typedef enum logic {IDLE, SEND} stateType;

    stateType         stateReg, stateNext;
    logic [SIZE-1:0]  wordReg, wordNext;
    logic [SIZE-1:0]  pendReg, pendNext;
    logic             pendVReg, pendVNext;
    logic [CNT_W-1:0] cntReg, cntNext;
    logic [7:0]       dataOutReg, dataOutNext;
    logic             validOutReg, validOutNext;
    logic             idleReg;
    logic             readyOut;
    logic             accept;
    logic             lastByte;
    logic [7:0]       byteLane [LANES];

    // Lanes beyond N only exist so the counter can index a power-of-two table.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : gLane
            if (gi < N) begin : gUsed
`ifdef SIZE_DECONVERT_MSB_FIRST_EN
                assign byteLane[gi] = wordReg[SIZE-1-8*gi -: 8];
`else
                assign byteLane[gi] = wordReg[8*gi +: 8];
`endif
            end else begin : gUnused
                assign byteLane[gi] = 8'h00;
            end
        end
    endgenerate

    assign readyOut        = RESET & ~pendVReg;
    assign accept          = bus.VALID_IN & readyOut;
    assign lastByte        = (cntReg == CNT_W'(N - 1));
    assign bus.READY_OUT   = readyOut;
    assign bus.DATA_OUT    = dataOutReg;
    assign bus.VALID_OUT   = validOutReg;
    assign bus.IDLE_BUFFER = idleReg;

    always_ff @(posedge PCLK or negedge RESET) begin
        if (!RESET) begin
            stateReg    <= IDLE;
            wordReg     <= '0;
            pendReg     <= '0;
            pendVReg    <= 1'b0;
            cntReg      <= '0;
            dataOutReg  <= IDLE_SYMBOL;
            validOutReg <= 1'b0;
            idleReg     <= 1'b1;
        end else begin
            stateReg    <= stateNext;
            wordReg     <= wordNext;
            pendReg     <= pendNext;
            pendVReg    <= pendVNext;
            cntReg      <= cntNext;
            dataOutReg  <= dataOutNext;
            validOutReg <= validOutNext;
            idleReg     <= ~validOutNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        wordNext     = wordReg;
        pendNext     = pendReg;
        pendVNext    = pendVReg;
        cntNext      = cntReg;
        dataOutNext  = IDLE_SYMBOL;
        validOutNext = 1'b0;
        case (stateReg)
            IDLE: begin
                if (accept) begin
                    wordNext  = bus.DATA_IN;
                    cntNext   = '0;
                    stateNext = SEND;
                end
            end
            SEND: begin
                dataOutNext  = byteLane[cntReg];
                validOutNext = 1'b1;
                if (lastByte) begin
                    // Pending word wins; READY_OUT is low while it is held, so no accept can race it.
                    if (pendVReg) begin
                        wordNext  = pendReg;
                        pendVNext = 1'b0;
                        cntNext   = '0;
                    end else if (accept) begin
                        wordNext = bus.DATA_IN;
                        cntNext  = '0;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    cntNext = cntReg + 1'b1;
                    if (accept) begin
                        pendNext  = bus.DATA_IN;
                        pendVNext = 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end
endmodule
